// File: rtl/exc_pkg.sv
// Shared types and constants for the precise-exception sequencer.
package exc_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN    = 3'd1,
        FLUSH    = 3'd2,
        REDIRECT = 3'd3,
        HALT     = 3'd4
    } state_t;

    localparam logic [1:0]  CAUSE_ITLB     = 2'd1;
    localparam logic [1:0]  CAUSE_DTLB     = 2'd2;
    localparam logic [31:0] HANDLER_PC_DEF = 32'h2000;

endpackage

// File: rtl/exception_ctrl.sv
// Precise-exception sequencer: capture fault at ROB head, drain stores, flush,
// redirect fetch to the handler (or back on iret), and track privilege mode.
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int                  WORD_SIZE    = 32,
    parameter int                  CAUSE_W      = 2,
    parameter int                  FLUSH_CYCLES = 2,
    parameter logic [WORD_SIZE-1:0] HANDLER_PC  = WORD_SIZE'(HANDLER_PC_DEF)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rob_exception,
    input  logic [WORD_SIZE-1:0] rob_ex_pc,
    input  logic [WORD_SIZE-1:0] rob_ex_vaddr,
    input  logic [CAUSE_W-1:0]   rob_ex_cause,
    input  logic                 iret_commit,
    input  logic                 sb_empty,
    output logic                 busy,
    output logic                 rob_flush,
    output logic                 pipe_flush,
    output logic                 fetch_redirect,
    output logic [WORD_SIZE-1:0] fetch_redirect_pc,
    output logic [WORD_SIZE-1:0] exc_pc_q,
    output logic [WORD_SIZE-1:0] exc_vaddr_q,
    output logic [CAUSE_W-1:0]   exc_cause_q,
    output logic                 priv_mode,
    output logic                 halted
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             ret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            ret_q       <= 1'b0;
            priv_mode   <= 1'b0;
            exc_pc_q    <= '0;
            exc_vaddr_q <= '0;
            exc_cause_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A fault inside the handler is unrecoverable; keep the first fault's state.
                    if (rob_exception) begin
                        if (priv_mode) begin
                            state <= HALT;
                        end else begin
                            exc_pc_q    <= rob_ex_pc;
                            exc_vaddr_q <= rob_ex_vaddr;
                            exc_cause_q <= rob_ex_cause;
                            ret_q       <= 1'b0;
                            state       <= DRAIN;
                        end
                    end else if (iret_commit) begin
                        ret_q <= 1'b1;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (sb_empty) begin
                        state <= FLUSH;
                        cnt   <= CNT_W'(FLUSH_CYCLES - 1);
                    end
                end
                FLUSH: begin
                    if (cnt == '0) state <= REDIRECT;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                REDIRECT: begin
                    priv_mode <= !ret_q;
                    state     <= IDLE;
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    // Moore outputs: decoded from state (and captured registers) only.
    assign busy              = (state != IDLE);
    assign rob_flush         = (state == FLUSH) || (state == HALT);
    assign pipe_flush        = rob_flush;
    assign fetch_redirect    = (state == REDIRECT);
    assign fetch_redirect_pc = fetch_redirect ? (ret_q ? exc_pc_q : HANDLER_PC) : '0;
    assign halted            = (state == HALT);

endmodule
